// File: rtl/match_arbiter.sv
// Round-robin arbiter that collects tracklet candidates over a fixed event window
// and emits the minimum-residual candidate for each run of equal tracklet ids.
module match_arbiter #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 7,
  parameter int RES_W      = 10,
  parameter int MAX_CYCLES = 108
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ID_W-1:0]  req_id,
  input  logic [NREQ*RES_W-1:0] req_res,
  output logic [NREQ-1:0]       grant,
  output logic                  match_valid,
  output logic [ID_W-1:0]       match_id,
  output logic [RES_W-1:0]      match_res,
  output logic [1:0]            match_src,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic res_better(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b);
    return a < b;
  endfunction

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic [ID_W-1:0]  cand_id;
  logic [RES_W-1:0] cand_res;
  logic             cnt_last;

  logic             vld_p0;
  logic [ID_W-1:0]  id_p0;
  logic [RES_W-1:0] res_p0;
  logic [PTR_W-1:0] src_p0;

  logic             vld_p1;
  logic [ID_W-1:0]  id_p1;
  logic [RES_W-1:0] res_p1;
  logic [PTR_W-1:0] src_p1;

  logic             held_same;
  logic             load_p0;
  logic             emit;

  // Arbitration: first requesting lane at or after the pointer, wrapping.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    if (state == S_RUN) begin
      for (int i = 0; i < NREQ; i++) begin
        j = (int'(ptr) + i) % NREQ;
        if (!gnt_any && req[j]) begin
          gnt_any  = 1'b1;
          gnt_idx  = j[PTR_W-1:0];
          grant[j] = 1'b1;
        end
      end
    end
  end

  assign ptr_nxt  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign cand_id  = req_id[gnt_idx*ID_W +: ID_W];
  assign cand_res = req_res[gnt_idx*RES_W +: RES_W];
  assign cnt_last = (cnt == CNT_W'(MAX_CYCLES - 1));

  // A new id flushes the held candidate; an equal id only wins on a strictly smaller residual.
  assign held_same = vld_p0 && (id_p0 == cand_id);
  assign load_p0   = gnt_any && (!held_same || res_better(cand_res, res_p0));
  assign emit      = (gnt_any && vld_p0 && !held_same) || (state == S_FLUSH && vld_p0);

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      match_valid <= 1'b0;
      match_id    <= '0;
      match_res   <= '0;
      match_src   <= '0;
      done        <= 1'b0;
    end else begin
      vld_p1      <= emit;
      match_valid <= vld_p1;
      done        <= 1'b0;
      if (vld_p1) begin
        match_id  <= id_p1;
        match_res <= res_p1;
        match_src <= 2'(src_p1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            cnt    <= '0;
            ptr    <= '0;
            vld_p0 <= 1'b0;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (gnt_any) begin
            ptr    <= ptr_nxt;
            vld_p0 <= 1'b1;
          end
          if (cnt_last) state <= S_FLUSH;
        end
        S_FLUSH: begin
          vld_p0 <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (start) begin
            state  <= S_RUN;
            cnt    <= '0;
            ptr    <= '0;
            vld_p0 <= 1'b0;
          end else begin
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Held-candidate (p0) and pending-emission (p1) payloads; qualified by vld_p0 / vld_p1.
  always_ff @(posedge clk) begin
    if (load_p0) begin
      id_p0  <= cand_id;
      res_p0 <= cand_res;
      src_p0 <= gnt_idx;
    end
    if (emit) begin
      id_p1  <= id_p0;
      res_p1 <= res_p0;
      src_p1 <= src_p0;
    end
  end

endmodule

// File: doc/match_arbiter.md
MATCH_ARBITER -- requirements
Module: match_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, fixed number of candidate requesters.
REQ-002 SHALL have parameter ID_W, default 7, tracklet index width.
REQ-003 SHALL have parameter RES_W, default 10, unsigned residual width.
REQ-004 SHALL have parameter MAX_CYCLES, default 108, RUN-window length in clk cycles.
REQ-005 SHALL have port clk  input  1  clock, rising-edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle pulse opening a new event window.
REQ-008 SHALL have port req  input  NREQ  per-requester candidate-present flags.
REQ-009 SHALL have port req_id  input  NREQ*ID_W  packed tracklet indices; requester k occupies bits [k*ID_W +: ID_W].
REQ-010 SHALL have port req_res  input  NREQ*RES_W  packed residuals; requester k occupies bits [k*RES_W +: RES_W].
REQ-011 SHALL have port grant  output  NREQ  one-hot combinational grant; the candidate is consumed when req[k]&grant[k].
REQ-012 SHALL have port match_valid  output  1  registered pulse marking a best match.
REQ-013 SHALL have port match_id  output  ID_W  tracklet index of the emitted match.
REQ-014 SHALL have port match_res  output  RES_W  minimum residual for that tracklet.
REQ-015 SHALL have port match_src  output  2  requester index that supplied the emitted match.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port done  output  1  registered one-cycle end-of-event pulse.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, RUN, FLUSH, DONE.
REQ-019 IDLE SHALL go to RUN on start, clearing the window counter, the round-robin pointer and the held-candidate register; otherwise it SHALL hold.
REQ-020 grant SHALL be 0 in every state except RUN.
REQ-021 In RUN, grant SHALL go to the first requester with req high, searching from pointer, pointer+1, ... modulo NREQ; if no req is high, grant SHALL be 0.
REQ-022 On a grant to requester k, pointer SHALL become (k+1) mod NREQ; with no grant, pointer SHALL hold.
REQ-023 Accepted candidate, held register empty: the candidate SHALL be loaded with id, residual and source.
REQ-024 Accepted candidate with id equal to held id: it SHALL replace the held candidate only if its residual is strictly less; ties SHALL keep the earlier candidate.
REQ-025 Accepted candidate with id different from held id: the held candidate SHALL be emitted and the new candidate loaded, in the same cycle.
REQ-026 Emission latency SHALL be one cycle: if the triggering acceptance is at edge N, match_valid is high for exactly the cycle after edge N+1, carrying the held values.
REQ-027 The window counter SHALL increment every RUN cycle; in the cycle where it equals MAX_CYCLES-1, a candidate SHALL still be accepted, and the FSM SHALL go to FLUSH.
REQ-028 FLUSH SHALL last one cycle: it emits the held candidate if one exists (no pulse if empty), clears the held register and goes to DONE.
REQ-029 DONE SHALL last one cycle with done high; it goes to RUN if start is high in that cycle (same initialisation as REQ-019), else to IDLE.
REQ-030 start SHALL be ignored in RUN and FLUSH.
REQ-031 At most one match_valid pulse SHALL occur per cycle; match_id, match_res and match_src SHALL hold their last values when match_valid is low.
REQ-032 Residual comparison SHALL be unsigned and RES_W wide, with no saturation.

Reset
REQ-033 Reset SHALL force, asynchronously: state IDLE; pointer 0; held register empty; counter 0; grant, match_valid, match_id, match_res, match_src, busy and done all 0.
REQ-034 Reset asserted mid-RUN SHALL discard the held candidate without emitting it.

Verification
REQ-035 Scenario: start; req=4'b0001 for 3 cycles with id 5, residuals 40, 30, 30; then id 6 residual 9 -> one pulse (id 5, res 30, src 0) one cycle after id 6 is accepted; FLUSH then emits (id 6, res 9, src 0).
REQ-036 Scenario: req=4'b1111 held high for 8 RUN cycles -> grant sequence 0001, 0010, 0100, 1000, repeating; never two bits set.
REQ-037 Scenario: start with no req for 108 cycles -> no match_valid; done pulses once, 110 cycles after start (108 RUN + FLUSH + DONE); busy falls the following cycle.
REQ-038 Scenario: candidate accepted on the last RUN cycle (counter=107) -> it is accepted and emitted in FLUSH.
REQ-039 Scenario: start pulsed in the DONE cycle -> FSM enters RUN directly, pointer is 0, and busy stays high with no gap.
REQ-040 Scenario: reset asserted mid-RUN while a candidate is held -> all outputs 0 immediately, no match_valid afterwards.
